// File: rtl/wave_meas_pkg.sv
// Shared types and analyzer widths for the wave measurement controller.
// The analyzer uses the same width constants.
package wave_meas_pkg;

    localparam int FREQ_W = 22;
    localparam int AMP_W  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } meas_state_t;

endpackage

// File: rtl/wave_meas_ctrl_if.sv
// Control/result bundle between the measurement controller and its host/analyzer side.
interface wave_meas_ctrl_if #(
    parameter int FREQ_W = wave_meas_pkg::FREQ_W,
    parameter int AMP_W  = wave_meas_pkg::AMP_W
);
    logic              start;
    logic              cont;
    logic [FREQ_W-1:0] freq_in;
    logic [AMP_W-1:0]  amp_in;
    logic              ana_clr;
    logic [FREQ_W-1:0] period_out;
    logic [AMP_W-1:0]  amp_out;
    logic              meas_valid;
    logic              no_signal;
    logic              busy;

    modport master (
        output start, cont, freq_in, amp_in,
        input  ana_clr, period_out, amp_out, meas_valid, no_signal, busy
    );

    modport slave (
        input  start, cont, freq_in, amp_in,
        output ana_clr, period_out, amp_out, meas_valid, no_signal, busy
    );
endinterface

// File: rtl/freq_stable_det.sv
// Detects that the analyzer period count has settled: STAB_CYC consecutive
// cycles with an unchanged, nonzero value.
module freq_stable_det #(
    parameter int FREQ_W   = wave_meas_pkg::FREQ_W,
    parameter int STAB_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [FREQ_W-1:0] freq_in,
    output logic              stable
);
    localparam int              CNT_W = $clog2(STAB_CYC) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STAB_CYC - 1);

    logic [FREQ_W-1:0] freq_q_r;
    logic [CNT_W-1:0]  stab_cnt_r;
    logic              qual_s;

    // A cycle qualifies when the count is nonzero and matches last cycle's value
    always_comb begin
        qual_s = (freq_in != {FREQ_W{1'b0}}) && (freq_in == freq_q_r);
    end

    // Previous-cycle copy of the period count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q_r <= {FREQ_W{1'b0}};
        end else begin
            freq_q_r <= freq_in;
        end
    end

    // Run-length of qualifying cycles; holds at LAST so it cannot wrap while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            stab_cnt_r <= {CNT_W{1'b0}};
        end else if (qual_s) begin
            if (stab_cnt_r != LAST) begin
                stab_cnt_r <= stab_cnt_r + CNT_W'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end else begin
            stab_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign stable = qual_s && (stab_cnt_r == LAST);

endmodule

// File: rtl/wave_meas_ctrl.sv
// Measurement controller: clears the analyzer, waits for a settled period count,
// averages 2**AVG_LOG2 captures and publishes one result (or a timeout) per set.
module wave_meas_ctrl #(
    parameter int FREQ_W   = wave_meas_pkg::FREQ_W,
    parameter int AMP_W    = wave_meas_pkg::AMP_W,
    parameter int WIN_CYC  = 4_000_000,
    parameter int STAB_CYC = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    wave_meas_ctrl_if.slave   bus
);
    import wave_meas_pkg::*;

    localparam int ACC_P_W = FREQ_W + AVG_LOG2;
    localparam int ACC_A_W = AMP_W + AVG_LOG2;
    localparam int WIN_W   = $clog2(WIN_CYC) + 1;
    localparam int N_W     = AVG_LOG2 + 1;
    localparam int NCAP    = 1 << AVG_LOG2;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(NCAP - 1);

    meas_state_t        state_r;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [N_W-1:0]     n_r;
    logic [ACC_P_W-1:0] acc_p_r;
    logic [ACC_A_W-1:0] acc_a_r;
    logic               ana_clr_r;
    logic [FREQ_W-1:0]  period_out_r;
    logic [AMP_W-1:0]   amp_out_r;
    logic               meas_valid_r;
    logic               no_signal_r;
    logic               busy_r;
    logic               stable_s;
    logic               clr_s;

    always_comb begin
        clr_s = (state_r == CLR);
    end

    freq_stable_det #(
        .FREQ_W   (FREQ_W),
        .STAB_CYC (STAB_CYC)
    ) u_stab (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .freq_in (bus.freq_in),
        .stable  (stable_s)
    );

    // Measurement FSM with registered outputs; ana_clr/busy are set on entry to their states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            win_cnt_r    <= {WIN_W{1'b0}};
            n_r          <= {N_W{1'b0}};
            acc_p_r      <= {ACC_P_W{1'b0}};
            acc_a_r      <= {ACC_A_W{1'b0}};
            ana_clr_r    <= 1'b0;
            period_out_r <= {FREQ_W{1'b0}};
            amp_out_r    <= {AMP_W{1'b0}};
            meas_valid_r <= 1'b0;
            no_signal_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            ana_clr_r    <= 1'b0;
            meas_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start || bus.cont) begin
                        state_r   <= CLR;
                        ana_clr_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                CLR: begin
                    win_cnt_r <= {WIN_W{1'b0}};
                    state_r   <= WAIT;
                end
                WAIT: begin
                    win_cnt_r <= win_cnt_r + WIN_W'(1);
                    // Stability takes priority over a coincident window end
                    if (stable_s) begin
                        state_r <= CAPT;
                    end else if (win_cnt_r == WIN_LAST) begin
                        state_r <= ABORT;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                CAPT: begin
                    acc_p_r <= acc_p_r + ACC_P_W'(bus.freq_in);
                    acc_a_r <= acc_a_r + ACC_A_W'(bus.amp_in);
                    n_r     <= n_r + N_W'(1);
                    if (n_r == N_LAST) begin
                        state_r   <= DONE;
                    end else begin
                        state_r   <= CLR;
                        ana_clr_r <= 1'b1;
                    end
                end
                DONE: begin
                    period_out_r <= FREQ_W'(acc_p_r >> AVG_LOG2);
                    amp_out_r    <= AMP_W'(acc_a_r >> AVG_LOG2);
                    no_signal_r  <= 1'b0;
                    meas_valid_r <= 1'b1;
                    acc_p_r      <= {ACC_P_W{1'b0}};
                    acc_a_r      <= {ACC_A_W{1'b0}};
                    n_r          <= {N_W{1'b0}};
                    if (bus.cont) begin
                        state_r   <= CLR;
                        ana_clr_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                ABORT: begin
                    period_out_r <= {FREQ_W{1'b0}};
                    amp_out_r    <= {AMP_W{1'b0}};
                    no_signal_r  <= 1'b1;
                    meas_valid_r <= 1'b1;
                    acc_p_r      <= {ACC_P_W{1'b0}};
                    acc_a_r      <= {ACC_A_W{1'b0}};
                    n_r          <= {N_W{1'b0}};
                    if (bus.cont) begin
                        state_r   <= CLR;
                        ana_clr_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ana_clr    = ana_clr_r;
    assign bus.period_out = period_out_r;
    assign bus.amp_out    = amp_out_r;
    assign bus.meas_valid = meas_valid_r;
    assign bus.no_signal  = no_signal_r;
    assign bus.busy       = busy_r;

endmodule
